// File: rtl/axi_stream_strip_header_if.sv
// Bundle of config, input stream, payload and header handshakes for the header stripper.
// slave = the stripper itself, master = the surrounding logic that feeds and drains it.
interface axi_stream_strip_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_strip;
  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt;
  logic                    ready_strip;

  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_hdr;
  logic [DATA_WD-1:0]      data_hdr;
  logic [DATA_BYTE_WD-1:0] keep_hdr;
  logic                    ready_hdr;

  modport slave (
    input  valid_strip, byte_strip_cnt,
    output ready_strip,
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    output valid_hdr, data_hdr, keep_hdr,
    input  ready_hdr
  );

  modport master (
    output valid_strip, byte_strip_cnt,
    input  ready_strip,
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    input  valid_hdr, data_hdr, keep_hdr,
    output ready_hdr
  );
endinterface

// File: rtl/axi_stream_strip_header.sv
// Strips an N-byte leading header from an AXI-Stream packet onto a separate header port
// (right-aligned) and emits the remaining payload realigned to byte 0 (the MSB byte).
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic clk,
  input logic rst_n,
  axi_stream_strip_header_if.slave bus
);

  localparam int W     = DATA_BYTE_WD;
  localparam int CNT_W = BYTE_CNT_WD + 1;
  localparam int P_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] W_CNT    = CNT_W'(W);
  localparam logic [P_W-1:0]   W_PCNT   = P_W'(W);
  localparam logic [W-1:0]     ALL_KEEP = '1;

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [DATA_WD-1:0] res_q, res_d;
  logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

  logic               valid_out_q, valid_out_d;
  logic [DATA_WD-1:0] data_out_q, data_out_d;
  logic [W-1:0]       keep_out_q, keep_out_d;
  logic               last_out_q, last_out_d;

  logic               valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0] data_hdr_q, data_hdr_d;
  logic [W-1:0]       keep_hdr_q, keep_hdr_d;

  logic               ready_in;
  logic               out_free;
  logic               hdr_free;
  logic [CNT_W-1:0]   k_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   m_cnt;
  logic [P_W-1:0]     p_cnt;
  logic [DATA_WD-1:0] masked_in;
  logic [DATA_WD-1:0] merged;

  function automatic logic [CNT_W-1:0] popcount(input logic [W-1:0] keep);
    popcount = '0;
    for (int i = 0; i < W; i++) begin
      popcount = popcount + CNT_W'(keep[i]);
    end
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] keep);
    byte_mask = '0;
    for (int i = 0; i < W; i++) begin
      byte_mask[8*i +: 8] = {8{keep[i]}};
    end
  endfunction

  // Keep with the top p byte lanes set; p may equal W.
  function automatic logic [W-1:0] top_keep(input logic [P_W-1:0] p);
    top_keep = ~(ALL_KEEP >> p);
  endfunction

  assign out_free  = !valid_out_q || bus.ready_out;
  assign hdr_free  = !valid_hdr_q || bus.ready_hdr;
  assign k_cnt     = popcount(bus.keep_in);
  assign r_cnt     = W_CNT - n_q;
  assign m_cnt     = (bus.last_in && (k_cnt < n_q)) ? k_cnt : n_q;
  assign p_cnt     = {1'b0, r_cnt} + {1'b0, k_cnt};
  assign masked_in = bus.data_in & byte_mask(bus.keep_in);
  // Non-last beats are treated as fully kept, so only the last beat uses the masked copy.
  assign merged    = res_q | ((bus.last_in ? masked_in : bus.data_in) >> {r_cnt, 3'b000});

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    valid_hdr_d = valid_hdr_q;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    ready_in    = 1'b0;

    if (bus.ready_out) begin
      valid_out_d = 1'b0;
    end
    if (valid_hdr_q && bus.ready_hdr) begin
      valid_hdr_d = 1'b0;
      data_hdr_d  = '0;
      keep_hdr_d  = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.valid_strip) begin
          n_d       = CNT_W'(bus.byte_strip_cnt) + CNT_W'(1);
          res_d     = '0;
          res_cnt_d = '0;
          state_d   = FIRST;
        end
      end

      FIRST: begin
        ready_in = out_free && hdr_free;
        if (bus.valid_in && ready_in) begin
          valid_hdr_d = 1'b1;
          data_hdr_d  = bus.data_in >> {(W_CNT - m_cnt), 3'b000};
          keep_hdr_d  = ~(ALL_KEEP << m_cnt);
          res_d       = bus.data_in << {n_q, 3'b000};
          if (bus.last_in) begin
            // A short packet may end inside the header, leaving nothing to emit.
            if (k_cnt > n_q) begin
              valid_out_d = 1'b1;
              data_out_d  = masked_in << {n_q, 3'b000};
              keep_out_d  = top_keep({1'b0, k_cnt - n_q});
              last_out_d  = 1'b1;
            end
            res_d   = '0;
            state_d = IDLE;
          end else begin
            state_d = STREAM;
          end
        end
      end

      STREAM: begin
        ready_in = out_free;
        if (bus.valid_in && ready_in) begin
          valid_out_d = 1'b1;
          data_out_d  = merged;
          if (!bus.last_in) begin
            keep_out_d = ALL_KEEP;
            last_out_d = 1'b0;
            res_d      = bus.data_in << {n_q, 3'b000};
          end else if (p_cnt <= W_PCNT) begin
            keep_out_d = top_keep(p_cnt);
            last_out_d = 1'b1;
            res_d      = '0;
            state_d    = IDLE;
          end else begin
            keep_out_d = ALL_KEEP;
            last_out_d = 1'b0;
            res_d      = masked_in << {n_q, 3'b000};
            res_cnt_d  = CNT_W'(p_cnt - W_PCNT);
            state_d    = FLUSH;
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          valid_out_d = 1'b1;
          data_out_d  = res_q;
          keep_out_d  = top_keep({1'b0, res_cnt_q});
          last_out_d  = 1'b1;
          res_d       = '0;
          res_cnt_d   = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      res_q       <= '0;
      res_cnt_q   <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      valid_hdr_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      valid_hdr_q <= valid_hdr_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign bus.ready_strip = (state_q == IDLE);
  assign bus.ready_in    = ready_in;
  assign bus.valid_out   = valid_out_q;
  assign bus.data_out    = data_out_q;
  assign bus.keep_out    = keep_out_q;
  assign bus.last_out    = last_out_q;
  assign bus.valid_hdr   = valid_hdr_q;
  assign bus.data_hdr    = data_hdr_q;
  assign bus.keep_hdr    = keep_hdr_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header (W=4): directed packets push expected
// header/payload beats into queues; independent monitors pop and compare on handshakes.
module tb_axi_stream_strip_header;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } out_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } hdr_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic hdr_hold;
  logic toggle_mode;
  out_t exp_out[$];
  hdr_t exp_hdr[$];

  axi_stream_strip_header_if #(.DATA_WD(32)) bus ();

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [31:0] data, input logic [3:0] keep, input logic last);
    bit got;
    got = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = data;
    bus.keep_in  = keep;
    bus.last_in  = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ready_in) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept: beat %h never accepted", data);
    end
  endtask

  task automatic start_packet(input int n);
    bit got;
    got = 0;
    bus.valid_strip    = 1'b1;
    bus.byte_strip_cnt = 2'(n - 1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ready_strip) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.valid_strip = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL config_accept: ready_strip never high");
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_out.size() == 0 && exp_hdr.size() == 0 && !bus.valid_out && !bus.valid_hdr) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain: pending out %0d hdr %0d expected 0 0", exp_out.size(), exp_hdr.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_out(input logic [31:0] d, input logic [3:0] k, input logic l);
    out_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    exp_out.push_back(e);
  endtask

  task automatic push_hdr(input logic [31:0] d, input logic [3:0] k);
    hdr_t e;
    e.data = d;
    e.keep = k;
    exp_hdr.push_back(e);
  endtask

  // Sink-side ready generation: header stall is controlled by hdr_hold, payload by toggle_mode.
  initial begin
    bus.ready_out = 1'b1;
    bus.ready_hdr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ready_hdr = !hdr_hold;
      bus.ready_out = toggle_mode ? !bus.ready_out : 1'b1;
    end
  end

  // Payload monitor: compares handshaken beats and checks stability across stalls.
  initial begin
    logic  out_stalled;
    out_t  prev;
    out_t  cur;
    out_t  e;
    out_stalled = 1'b0;
    prev        = '0;
    forever begin
      @(negedge clk);
      cur = {bus.data_out, bus.keep_out, bus.last_out};
      if (rst_n) begin
        if (out_stalled) begin
          checkOutput("out_hold_valid", 64'(bus.valid_out), 64'(1));
          checkOutput("out_hold_beat", 64'(cur), 64'(prev));
        end
        if (bus.valid_out && bus.ready_out) begin
          if (exp_out.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_unexpected: got beat %h, expected no beat", cur);
          end else begin
            e = exp_out.pop_front();
            checkOutput("out_beat", 64'(cur), 64'(e));
          end
        end
        out_stalled = bus.valid_out && !bus.ready_out;
        prev        = cur;
      end else begin
        out_stalled = 1'b0;
      end
    end
  end

  // Header monitor, independent of the payload side.
  initial begin
    logic hdr_stalled;
    hdr_t prev;
    hdr_t cur;
    hdr_t e;
    hdr_stalled = 1'b0;
    prev        = '0;
    forever begin
      @(negedge clk);
      cur = {bus.data_hdr, bus.keep_hdr};
      if (rst_n) begin
        if (hdr_stalled) begin
          checkOutput("hdr_hold_valid", 64'(bus.valid_hdr), 64'(1));
          checkOutput("hdr_hold_beat", 64'(cur), 64'(prev));
        end
        if (bus.valid_hdr && bus.ready_hdr) begin
          if (exp_hdr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL hdr_unexpected: got header %h, expected none", cur);
          end else begin
            e = exp_hdr.pop_front();
            checkOutput("hdr_beat", 64'(cur), 64'(e));
          end
        end
        hdr_stalled = bus.valid_hdr && !bus.ready_hdr;
        prev        = cur;
      end else begin
        hdr_stalled = 1'b0;
      end
    end
  end

  task automatic check_reset_values();
    checkOutput("rst_valid_out", 64'(bus.valid_out), 64'(0));
    checkOutput("rst_data_out", 64'(bus.data_out), 64'(0));
    checkOutput("rst_keep_out", 64'(bus.keep_out), 64'(0));
    checkOutput("rst_last_out", 64'(bus.last_out), 64'(0));
    checkOutput("rst_valid_hdr", 64'(bus.valid_hdr), 64'(0));
    checkOutput("rst_data_hdr", 64'(bus.data_hdr), 64'(0));
    checkOutput("rst_keep_hdr", 64'(bus.keep_hdr), 64'(0));
    checkOutput("rst_ready_in", 64'(bus.ready_in), 64'(0));
    checkOutput("rst_ready_strip", 64'(bus.ready_strip), 64'(1));
  endtask

  task automatic expect_test1();
    push_hdr(32'h0000_1122, 4'b0011);
    push_out(32'h3344_5566, 4'b1111, 1'b0);
    push_out(32'h7788_AABB, 4'b1111, 1'b0);
    push_out(32'hCCDD_0000, 4'b1100, 1'b1);
  endtask

  task automatic run_test2();
    push_hdr(32'h0102_0304, 4'b1111);
    push_out(32'h0506_0700, 4'b1110, 1'b1);
    start_packet(4);
    applyStimulus(32'h0102_0304, 4'b1111, 1'b0);
    applyStimulus(32'h0506_0708, 4'b1110, 1'b1);
    wait_drain();
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    hdr_hold           = 1'b0;
    toggle_mode        = 1'b0;
    rst_n              = 1'b0;
    bus.valid_strip    = 1'b0;
    bus.byte_strip_cnt = '0;
    bus.valid_in       = 1'b0;
    bus.data_in        = '0;
    bus.keep_in        = '0;
    bus.last_in        = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: N=2 three-beat packet with flush");
    expect_test1();
    start_packet(2);
    applyStimulus(32'h1122_3344, 4'b1111, 1'b0);
    applyStimulus(32'h5566_7788, 4'b1111, 1'b0);
    applyStimulus(32'hAABB_CCDD, 4'b1111, 1'b1);
    wait_drain();

    $display("[TB] test 2: N=4 pass-through");
    run_test2();

    $display("[TB] test 3: N=1 single short beat");
    push_hdr(32'h0000_00AA, 4'b0001);
    push_out(32'hBB00_0000, 4'b1000, 1'b1);
    start_packet(1);
    applyStimulus(32'hAABB_1234, 4'b1100, 1'b1);
    wait_drain();

    $display("[TB] test 4: N=3 packet shorter than header");
    push_hdr(32'h0000_00AA, 4'b0001);
    start_packet(3);
    applyStimulus(32'hAA12_3456, 4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("t4_ready_strip", 64'(bus.ready_strip), 64'(1));
    wait_drain();

    $display("[TB] test 5: stalled header blocks FIRST, toggling payload ready");
    @(negedge clk);
    hdr_hold    = 1'b1;
    toggle_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push_hdr(32'h0000_00AA, 4'b0001);
    push_out(32'hBB00_0000, 4'b1000, 1'b1);
    start_packet(1);
    applyStimulus(32'hAABB_1234, 4'b1100, 1'b1);
    expect_test1();
    start_packet(2);
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h1122_3344;
    bus.keep_in  = 4'b1111;
    bus.last_in  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5_ready_in_blocked", 64'(bus.ready_in), 64'(0));
    end
    hdr_hold = 1'b0;
    applyStimulus(32'h1122_3344, 4'b1111, 1'b0);
    applyStimulus(32'h5566_7788, 4'b1111, 1'b0);
    applyStimulus(32'hAABB_CCDD, 4'b1111, 1'b1);
    wait_drain();
    @(negedge clk);
    toggle_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] test 6: reset during STREAM, then a clean packet");
    push_hdr(32'h0000_1122, 4'b0011);
    push_out(32'h3344_5566, 4'b1111, 1'b0);
    start_packet(2);
    applyStimulus(32'h1122_3344, 4'b1111, 1'b0);
    applyStimulus(32'h5566_7788, 4'b1111, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_queue_out", 64'(exp_out.size()), 64'(0));
    run_test2();

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
